elpis_host_bridge: RTL and testbench

ELPIS_HOST_BRIDGE -- requirements
Module: elpis_host_bridge

---
 rtl/elpis_host_bridge.sv | 207 ++++++++++++++++++++
 tb/tb_elpis_host_bridge.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elpis_host_bridge.sv
// rtl/elpis_host_bridge.sv - host bridge: program loader, console input path, print capture FIFO
// Loader writes a host word stream into Elpis memory while holding the core in reset.
module elpis_host_bridge #(
  parameter int OUT_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic [19:0] load_base_addr,
  input  logic [19:0] load_word_count,
  input  logic        host_wr_valid,
  input  logic [31:0] host_wr_data,
  output logic        host_wr_ready,
  output logic        load_busy,
  output logic        load_done,
  output logic        is_loading_memory_into_core,
  output logic [19:0] addr_to_core_mem,
  output logic [31:0] data_to_core_mem,
  output logic        reset_core,
  input  logic        host_in_valid,
  input  logic [31:0] host_in_data,
  output logic        host_in_ready,
  output logic [31:0] read_value_to_Elpis,
  output logic        read_enable_to_Elpis,
  input  logic        output_enabled_from_elpis_to_pico,
  input  logic [31:0] output_data_from_elpis_to_pico,
  output logic        host_out_valid,
  output logic [31:0] host_out_data,
  input  logic        host_out_ready,
  output logic        out_overflow,
  input  logic        overflow_clr
);

  localparam int AW = $clog2(OUT_FIFO_DEPTH);
  localparam logic [AW:0] FIFO_FULL = (AW+1)'(OUT_FIFO_DEPTH);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t      state_q, state_d;
  logic [19:0] addr_q, addr_d;
  logic [19:0] remain_q, remain_d;
  logic        reset_core_q, reset_core_d;
  logic        done_nz_q, done_nz_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [19:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        load_done_q, load_done_d;
  logic        wr_accept;

  logic        rd_en_q, rd_en_d;
  logic [31:0] rd_value_q, rd_value_d;
  logic        in_accept;

  logic [31:0] mem_q [OUT_FIFO_DEPTH];
  logic [31:0] mem_d [OUT_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          fifo_full, fifo_empty, fifo_pop, fifo_push, ovf_event;

  // Loader state register and datapath flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remain_q     <= '0;
      reset_core_q <= 1'b1;
      done_nz_q    <= 1'b0;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      load_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      reset_core_q <= reset_core_d;
      done_nz_q    <= done_nz_d;
      wr_strobe_q  <= wr_strobe_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      load_done_q  <= load_done_d;
    end
  end

  assign wr_accept = host_wr_valid && (state_q == LOAD);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_start && (load_word_count != 20'd0)) state_d = LOAD;
      LOAD:    if (wr_accept && (remain_q == 20'd1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d       = addr_q;
    remain_d     = remain_q;
    reset_core_d = reset_core_q;
    done_nz_d    = 1'b0;
    wr_strobe_d  = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    load_done_d  = 1'b0;
    // Release the core one cycle after a real load completes; a new load start overrides.
    if (done_nz_q) reset_core_d = 1'b0;
    if ((state_q == IDLE) && load_start) begin
      if (load_word_count != 20'd0) begin
        addr_d       = load_base_addr;
        remain_d     = load_word_count;
        reset_core_d = 1'b1;
      end else begin
        load_done_d  = 1'b1;
      end
    end
    if (wr_accept) begin
      wr_strobe_d = 1'b1;
      wr_addr_d   = addr_q;
      wr_data_d   = host_wr_data;
      addr_d      = addr_q + 20'd1;
      remain_d    = remain_q - 20'd1;
      if (remain_q == 20'd1) begin
        load_done_d = 1'b1;
        done_nz_d   = 1'b1;
      end
    end
  end

  always_comb begin
    load_busy                   = (state_q == LOAD);
    host_wr_ready               = (state_q == LOAD);
    load_done                   = load_done_q;
    is_loading_memory_into_core = wr_strobe_q;
    addr_to_core_mem            = wr_addr_q;
    data_to_core_mem            = wr_data_q;
    reset_core                  = reset_core_q;
  end

  // Console input: one value per two cycles at most, since ready drops while the pulse is out.
  assign in_accept = host_in_valid && !rd_en_q;

  always_comb begin
    rd_en_d    = in_accept;
    rd_value_d = in_accept ? host_in_data : rd_value_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_en_q    <= 1'b0;
      rd_value_q <= '0;
    end else begin
      rd_en_q    <= rd_en_d;
      rd_value_q <= rd_value_d;
    end
  end

  assign host_in_ready        = !rd_en_q;
  assign read_enable_to_Elpis = rd_en_q;
  assign read_value_to_Elpis  = rd_value_q;

  // Print capture FIFO, first-word fall-through
  assign fifo_full  = (count_q == FIFO_FULL);
  assign fifo_empty = (count_q == '0);
  assign fifo_pop   = !fifo_empty && host_out_ready;
  assign fifo_push  = output_enabled_from_elpis_to_pico && (!fifo_full || fifo_pop);
  assign ovf_event  = output_enabled_from_elpis_to_pico && fifo_full && !fifo_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_push) begin
      mem_d[wr_ptr_q] = output_data_from_elpis_to_pico;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (fifo_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (fifo_push && !fifo_pop)      count_d = count_q + (AW+1)'(1);
    else if (fifo_pop && !fifo_push) count_d = count_q - (AW+1)'(1);
    if (ovf_event)         ovf_d = 1'b1;
    else if (overflow_clr) ovf_d = 1'b0;
    else                   ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign host_out_valid = !fifo_empty;
  assign host_out_data  = mem_q[rd_ptr_q];
  assign out_overflow   = ovf_q;

endmodule

// File: tb/tb_elpis_host_bridge.sv
// tb/tb_elpis_host_bridge.sv - scoreboard bench for elpis_host_bridge
module tb_elpis_host_bridge;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic [19:0] load_base_addr = '0;
  logic [19:0] load_word_count = '0;
  logic        host_wr_valid = 1'b0;
  logic [31:0] host_wr_data = '0;
  logic        host_wr_ready, load_busy, load_done, is_loading_memory_into_core;
  logic [19:0] addr_to_core_mem;
  logic [31:0] data_to_core_mem;
  logic        reset_core;
  logic        host_in_valid = 1'b0;
  logic [31:0] host_in_data = '0;
  logic        host_in_ready;
  logic [31:0] read_value_to_Elpis;
  logic        read_enable_to_Elpis;
  logic        out_en = 1'b0;
  logic [31:0] out_data = '0;
  logic        host_out_valid;
  logic [31:0] host_out_data;
  logic        host_out_ready = 1'b0;
  logic        out_overflow;
  logic        overflow_clr = 1'b0;

  elpis_host_bridge #(.OUT_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_base_addr(load_base_addr), .load_word_count(load_word_count),
    .host_wr_valid(host_wr_valid), .host_wr_data(host_wr_data), .host_wr_ready(host_wr_ready),
    .load_busy(load_busy), .load_done(load_done),
    .is_loading_memory_into_core(is_loading_memory_into_core),
    .addr_to_core_mem(addr_to_core_mem), .data_to_core_mem(data_to_core_mem),
    .reset_core(reset_core),
    .host_in_valid(host_in_valid), .host_in_data(host_in_data), .host_in_ready(host_in_ready),
    .read_value_to_Elpis(read_value_to_Elpis), .read_enable_to_Elpis(read_enable_to_Elpis),
    .output_enabled_from_elpis_to_pico(out_en), .output_data_from_elpis_to_pico(out_data),
    .host_out_valid(host_out_valid), .host_out_data(host_out_data), .host_out_ready(host_out_ready),
    .out_overflow(out_overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] addr;
    logic [31:0] data;
    bit          last;
  } wr_t;

  int          total = 0;
  int          bad = 0;
  wr_t         exp_wr[$];
  int          zero_done_pending = 0;
  logic [31:0] exp_in[$];
  logic [31:0] last_in_m = '0;
  bit          prev_en = 1'b0;
  logic [31:0] fifo_m[$];
  bit          ovf_m = 1'b0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Write-strobe monitor: every strobe must match the next expected memory write.
  always @(negedge clk) begin
    wr_t e;
    if (reset) begin
      if (is_loading_memory_into_core) begin
        chk1("strobe_expected", exp_wr.size() != 0, 1'b1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          chk32("wr_addr", {12'd0, addr_to_core_mem}, {12'd0, e.addr});
          chk32("wr_data", data_to_core_mem, e.data);
          chk1("done_with_last", load_done, e.last);
        end
      end else if (load_done) begin
        chk1("done_expected", zero_done_pending > 0, 1'b1);
        if (zero_done_pending > 0) zero_done_pending--;
      end
    end else begin
      exp_wr.delete();
      zero_done_pending = 0;
    end
  end

  // Console monitor
  always @(negedge clk) begin
    if (reset) begin
      if (read_enable_to_Elpis) begin
        chk1("in_ready_low", host_in_ready, 1'b0);
        chk1("in_single_pulse", prev_en, 1'b0);
        chk1("in_expected", exp_in.size() != 0, 1'b1);
        if (exp_in.size() != 0) last_in_m = exp_in.pop_front();
      end
      chk32("in_value", read_value_to_Elpis, last_in_m);
      prev_en = read_enable_to_Elpis;
    end else begin
      exp_in.delete();
      last_in_m = '0;
      prev_en = 1'b0;
    end
  end

  // FIFO model: decides this cycle's pop/push from inputs, updated ahead of the next edge.
  always @(negedge clk) begin
    bit pop;
    bit drop;
    if (reset) begin
      drop = 1'b0;
      chk1("out_valid", host_out_valid, fifo_m.size() != 0);
      chk1("out_overflow", out_overflow, ovf_m);
      if (fifo_m.size() != 0) chk32("out_head", host_out_data, fifo_m[0]);
      pop = (fifo_m.size() != 0) && host_out_ready;
      if (pop) void'(fifo_m.pop_front());
      if (out_en) begin
        if (fifo_m.size() < DEPTH) fifo_m.push_back(out_data);
        else drop = 1'b1;
      end
      if (drop) ovf_m = 1'b1;
      else if (overflow_clr) ovf_m = 1'b0;
    end else begin
      fifo_m.delete();
      ovf_m = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    host_wr_valid = 1'b1;
    host_wr_data  = w;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (host_wr_ready) begin
        step();
        host_wr_valid = 1'b0;
        return;
      end
    end
    chk1("wr_ready_timeout", host_wr_ready, 1'b1);
    host_wr_valid = 1'b0;
  endtask

  task automatic send_in(input logic [31:0] v);
    host_in_valid = 1'b1;
    host_in_data  = v;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (host_in_ready) begin
        exp_in.push_back(v);
        step();
        host_in_valid = 1'b0;
        return;
      end
    end
    chk1("in_ready_timeout", host_in_ready, 1'b1);
    host_in_valid = 1'b0;
  endtask

  task automatic start_load(input logic [19:0] base, input logic [19:0] cnt);
    load_start      = 1'b1;
    load_base_addr  = base;
    load_word_count = cnt;
    step();
    load_start = 1'b0;
  endtask

  task automatic run_load(input logic [19:0] base, input int n, input int gmin, input int gmax,
                          input bit mid_start);
    wr_t e;
    logic [31:0] w;
    int gap;
    start_load(base, 20'(n));
    chk1("busy_after_start", load_busy, 1'b1);
    chk1("core_held_in_load", reset_core, 1'b1);
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      e.addr = base + 20'(i);
      e.data = w;
      e.last = (i == n - 1);
      exp_wr.push_back(e);
      if (mid_start && i == 1) start_load(20'h55555, 20'd7);
      gap = $urandom_range(gmin, gmax);
      for (int g = 0; g < gap; g++) step();
      send_word(w);
    end
    chk1("done_at_last_strobe", load_done, 1'b1);
    chk1("core_still_reset", reset_core, 1'b1);
    step();
    chk1("core_released", reset_core, 1'b0);
    chk1("idle_after_load", load_busy, 1'b0);
    chk1("done_single_pulse", load_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_reset_core", reset_core, 1'b1);
    chk1("rst_busy", load_busy, 1'b0);
    chk1("rst_wr_ready", host_wr_ready, 1'b0);
    chk1("rst_strobe", is_loading_memory_into_core, 1'b0);
    chk1("rst_done", load_done, 1'b0);
    chk1("rst_rd_en", read_enable_to_Elpis, 1'b0);
    chk1("rst_out_valid", host_out_valid, 1'b0);
    chk1("rst_overflow", out_overflow, 1'b0);
    chk32("rst_addr", {12'd0, addr_to_core_mem}, 32'd0);
    reset = 1'b1;
    step();
    chk1("release_reset_core", reset_core, 1'b1);

    // Zero-length load
    zero_done_pending++;
    start_load(20'h00333, 20'd0);
    chk1("zero_done_pulse", load_done, 1'b1);
    chk1("zero_stays_idle", load_busy, 1'b0);
    chk1("zero_reset_core", reset_core, 1'b1);
    step();
    chk1("zero_done_once", load_done, 1'b0);

    run_load(20'h00010, 3, 0, 0, 1'b0);
    run_load(20'hFFFFE, 3, 1, 3, 1'b0);
    run_load(20'h00400, 4, 0, 2, 1'b1);
    for (int k = 0; k < 4; k++)
      run_load(20'hFFFF8 + 20'($urandom_range(0, 12)), $urandom_range(1, 6), 0, 3, 1'b0);

    // Console input
    send_in(32'h12345678);
    chk1("in_pulse", read_enable_to_Elpis, 1'b1);
    chk32("in_pulse_value", read_value_to_Elpis, 32'h12345678);
    chk1("in_ready_during_pulse", host_in_ready, 1'b0);
    step();
    chk1("in_pulse_ends", read_enable_to_Elpis, 1'b0);
    for (int k = 0; k < 10; k++) send_in($urandom);
    repeat (3) step();

    // FIFO fill past full with no consumer
    host_out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      out_en = 1'b1;
      out_data = 32'hA000_0000 + 32'(k);
      step();
    end
    out_en = 1'b0;
    chk1("overflow_set", out_overflow, 1'b1);
    chk32("head_first_word", host_out_data, 32'hA000_0000);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    chk1("overflow_cleared", out_overflow, 1'b0);
    out_en = 1'b1;
    out_data = 32'hB0B0_0001;
    host_out_ready = 1'b1;
    step();
    out_en = 1'b0;
    host_out_ready = 1'b0;
    chk1("push_pop_full_no_ovf", out_overflow, 1'b0);
    host_out_ready = 1'b1;
    repeat (6) step();
    host_out_ready = 1'b0;
    chk1("drained", host_out_valid, 1'b0);

    for (int k = 0; k < 300; k++) begin
      out_en = 1'($urandom_range(0, 1));
      out_data = $urandom;
      host_out_ready = ($urandom_range(0, 2) == 0);
      overflow_clr = ($urandom_range(0, 15) == 0);
      step();
    end
    out_en = 1'b0;
    overflow_clr = 1'b0;
    host_out_ready = 1'b1;
    repeat (6) step();
    host_out_ready = 1'b0;

    // Reset in the middle of a load
    start_load(20'h00100, 20'd5);
    for (int i = 0; i < 2; i++) begin
      wr_t e;
      logic [31:0] w;
      w = $urandom;
      e.addr = 20'h00100 + 20'(i);
      e.data = w;
      e.last = 1'b0;
      exp_wr.push_back(e);
      send_word(w);
    end
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk1("midrst_strobe", is_loading_memory_into_core, 1'b0);
    chk1("midrst_reset_core", reset_core, 1'b1);
    chk1("midrst_busy", load_busy, 1'b0);
    chk1("midrst_done", load_done, 1'b0);
    repeat (3) step();
    reset = 1'b1;
    host_wr_valid = 1'b1;
    host_wr_data = 32'hDEAD_BEEF;
    repeat (8) step();
    host_wr_valid = 1'b0;
    chk1("midrst_idle", load_busy, 1'b0);
    chk1("midrst_core_held", reset_core, 1'b1);

    repeat (5) step();
    chk1("all_writes_seen", exp_wr.size() == 0, 1'b1);
    chk1("all_zero_dones_seen", zero_done_pending == 0, 1'b1);
    chk1("all_inputs_seen", exp_in.size() == 0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
